// File: rtl/store_size_unit_pkg.sv
// Shared definitions for the store-size path: StoreSize encodings, FSM states
// and the read-latency counter width.
package store_size_unit_pkg;

  localparam logic [1:0] SS_WORD = 2'b00;
  localparam logic [1:0] SS_HALF = 2'b01;
  localparam logic [1:0] SS_BYTE = 2'b10;

  localparam int CNT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SS_HALF) || (size == SS_BYTE);
  endfunction

endpackage

// File: rtl/store_size_unit_byte_lane_merge.sv
// Little-endian byte-lane merge: drops the low byte or halfword of regb into
// the read word at the lane picked by addr_lo; word (and reserved) size passes regb.
module byte_lane_merge
  import store_size_unit_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] regb,
  input  logic [1:0]        size,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] merged
);

  always_comb begin
    merged = rd_word;
    case (size)
      SS_BYTE: merged[{addr_lo, 3'b000} +: 8]        = regb[7:0];
      SS_HALF: merged[{addr_lo[1], 4'b0000} +: 16]   = regb[15:0];
      default: merged                                = regb;
    endcase
  end

endmodule

// File: rtl/store_size_unit.sv
// Store-path sequencer: word stores write directly, sub-word stores do a
// read-modify-write. Optional alignment trap enabled by macro ALIGN_CHECK_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; latches request on start
// S_READ  | word address presented, down-counter covers read latency
// S_MERGE | MemData captured into word register at end of cycle
// S_WRITE | MemWr high, merged word driven
// S_DONE  | done pulse (misaligned with it on an alignment fault)
module store_size_unit
  import store_size_unit_pkg::*;
#(
  parameter int MEM_RD_LATENCY = 1,
  parameter int DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        StoreSize,
  input  logic [DATA_W-1:0] Address,
  input  logic [DATA_W-1:0] RegB,
  input  logic [DATA_W-1:0] MemData,
  output logic [DATA_W-1:0] MemAddr,
  output logic              MemWr,
  output logic [DATA_W-1:0] MemWriteData,
  output logic              busy,
  output logic              done,
  output logic              misaligned
);

  localparam logic [CNT_W-1:0] RD_LAT = CNT_W'(MEM_RD_LATENCY);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] addr_q, regb_q, word_q, merged;
  logic [1:0]        size_q;
  logic              fault;
  logic              accept;

  assign accept = (state_q == S_IDLE) && start;

`ifdef ALIGN_CHECK_EN
  logic mis_q;

  // reserved size behaves as a word store, so it shares the word alignment rule
  assign fault = ((StoreSize == SS_HALF) && Address[0]) ||
                 (!is_sub_word(StoreSize) && (Address[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else if (accept) mis_q <= fault;
  end

  assign misaligned = done && mis_q;
`else
  assign fault      = 1'b0;
  assign misaligned = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      regb_q  <= '0;
      size_q  <= SS_WORD;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q <= Address;
        regb_q <= RegB;
        size_q <= StoreSize;
      end
      if (state_q == S_MERGE) word_q <= MemData;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (fault) begin
            state_d = S_DONE;
          end else if (is_sub_word(StoreSize)) begin
            state_d = S_READ;
            cnt_d   = RD_LAT;
          end else begin
            state_d = S_WRITE;
          end
        end
      end
      S_READ: begin
        if (cnt_q == CNT_W'(1)) state_d = S_MERGE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      S_MERGE: state_d = S_WRITE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  byte_lane_merge #(.DATA_W(DATA_W)) u_merge (
    .rd_word (word_q),
    .regb    (regb_q),
    .size    (size_q),
    .addr_lo (addr_q[1:0]),
    .merged  (merged)
  );

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign MemWr        = (state_q == S_WRITE);
  assign MemAddr      = busy ? {addr_q[DATA_W-1:2], 2'b00} : '0;
  assign MemWriteData = MemWr ? merged : '0;

endmodule

// File: tb/tb_store_size_unit.sv
// Bench for store_size_unit: table of directed stores, hand-written reset and
// start-hold sequences, and random stores against a byte-level memory model.
module tb_store_size_unit;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  StoreSize;
  logic [31:0] Address, RegB, MemData, MemAddr, MemWriteData;
  logic        MemWr, busy, done, misaligned;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic [31:0] rd_pipe [LAT];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_val;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  store_size_unit #(.MEM_RD_LATENCY(LAT), .DATA_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .StoreSize    (StoreSize),
    .Address      (Address),
    .RegB         (RegB),
    .MemData      (MemData),
    .MemAddr      (MemAddr),
    .MemWr        (MemWr),
    .MemWriteData (MemWriteData),
    .busy         (busy),
    .done         (done),
    .misaligned   (misaligned)
  );

  // single-port memory with LAT-cycle read pipeline
  always @(posedge clk) begin
    if (MemWr) mem[MemAddr[7:2]] <= MemWriteData;
    else if (pre_en) mem[pre_idx] <= pre_val;
    for (int i = LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem[MemAddr[7:2]];
  end
  assign MemData = rd_pipe[LAT-1];

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [31:0] rb;
    logic [31:0] init;
    logic        wr;
    logic [31:0] word;
    logic [31:0] maddr;
    int          wk;
    int          dk;
    logic        mis;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    pre_idx = 6'(idx);
    pre_val = v;
    pre_en  = 1'b1;
    ref_mem[idx] = v;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  function automatic logic ref_fault(input logic [1:0] sz, input logic [31:0] ad);
`ifdef ALIGN_CHECK_EN
    if (sz == 2'b01) return ad[0];
    if (sz == 2'b10) return 1'b0;
    return ad[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] ref_merge(input logic [1:0] sz, input logic [31:0] ad,
                                            input logic [31:0] rb, input logic [31:0] old);
    logic [7:0] b [4];
    int base;
    for (int i = 0; i < 4; i++) b[i] = 8'((old >> (8 * i)) & 32'hFF);
    case (sz)
      2'b10: b[ad % 4] = rb[7:0];
      2'b01: begin
        base = (ad % 4) / 2 * 2;
        b[base]     = rb[7:0];
        b[base + 1] = rb[15:8];
      end
      default: return rb;
    endcase
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Issues one store from a negedge and watches it to the cycle after done.
  // k counts negedge samples after the capturing edge, so k=1 is cycle T+1.
  task automatic run_store(input logic [1:0] sz, input logic [31:0] ad, input logic [31:0] rb,
                           input int hold, output int wr_k, output int wr_cnt, output int done_k,
                           output logic [31:0] wr_addr, output logic [31:0] wr_data,
                           output logic mis, output logic busy_after, output int viol);
    StoreSize = sz; Address = ad; RegB = rb; start = 1'b1;
    wr_k = -1; wr_cnt = 0; done_k = -1; wr_addr = '0; wr_data = '0;
    mis = 1'b0; busy_after = 1'b1; viol = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (MemWr) begin
        wr_cnt++;
        if (wr_k < 0) begin wr_k = k; wr_addr = MemAddr; wr_data = MemWriteData; end
      end else if (MemWriteData !== 32'h0) viol++;
      if (busy && MemAddr !== {ad[31:2], 2'b00}) viol++;
      if (!busy && MemAddr !== 32'h0) viol++;
      if (done && !busy) viol++;
      if (done) begin
        if (done_k < 0) done_k = k;
        mis = mis | misaligned;
      end else if (misaligned) viol++;
      if (done_k < 0 && !busy) viol++;
      Address = $urandom;
      RegB    = $urandom;
      if (k >= hold) start = 1'b0;
      if (done_k > 0 && k == done_k + 1) begin
        busy_after = busy;
        if (done) viol++;
        break;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    vec_t        tbl[$];
    int          wk, wc, dk, viol, idx, exp_dk;
    logic [31:0] wa, wd, exp_w;
    logic        ms, ba, flt;
    logic [1:0]  sz;
    logic [31:0] ad, rb;

    reset = 1'b0; start = 1'b0; StoreSize = 2'b00; Address = '0; RegB = '0;
    pre_en = 1'b0; pre_idx = '0; pre_val = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",  {31'b0, busy}, 32'h0);
    check("rst_done",  {31'b0, done}, 32'h0);
    check("rst_memwr", {31'b0, MemWr}, 32'h0);
    check("rst_mis",   {31'b0, misaligned}, 32'h0);
    check("rst_addr",  MemAddr, 32'h0);
    check("rst_wdata", MemWriteData, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) preload(i, 32'h0);

    tbl.push_back('{2'b00, 32'h40, 32'hDEADBEEF, 32'h0,      1'b1, 32'hDEADBEEF, 32'h40, 1,       2,       1'b0});
    tbl.push_back('{2'b10, 32'h42, 32'h000000AB, 32'h11223344, 1'b1, 32'h11AB3344, 32'h40, LAT + 2, LAT + 3, 1'b0});
    tbl.push_back('{2'b01, 32'h46, 32'h0000CAFE, 32'h11223344, 1'b1, 32'hCAFE3344, 32'h44, LAT + 2, LAT + 3, 1'b0});
    tbl.push_back('{2'b10, 32'h48, 32'h12345677, 32'hAABBCCDD, 1'b1, 32'hAABBCC77, 32'h48, LAT + 2, LAT + 3, 1'b0});
    tbl.push_back('{2'b10, 32'h4B, 32'hFFFFFF01, 32'hAABBCCDD, 1'b1, 32'h01BBCCDD, 32'h48, LAT + 2, LAT + 3, 1'b0});
    tbl.push_back('{2'b10, 32'h4D, 32'h0000005A, 32'h0,      1'b1, 32'h00005A00, 32'h4C, LAT + 2, LAT + 3, 1'b0});
    tbl.push_back('{2'b01, 32'h50, 32'hFFFF1234, 32'h89ABCDEF, 1'b1, 32'h89AB1234, 32'h50, LAT + 2, LAT + 3, 1'b0});
    tbl.push_back('{2'b11, 32'h54, 32'h13579BDF, 32'h0,      1'b1, 32'h13579BDF, 32'h54, 1,       2,       1'b0});
`ifdef ALIGN_CHECK_EN
    tbl.push_back('{2'b01, 32'h43, 32'h0000BEEF, 32'h11223344, 1'b0, 32'h0,        32'h0,  -1,      1,       1'b1});
    tbl.push_back('{2'b00, 32'h5E, 32'hCAFEF00D, 32'h0,      1'b0, 32'h0,        32'h0,  -1,      1,       1'b1});
`else
    tbl.push_back('{2'b01, 32'h43, 32'h0000BEEF, 32'h11223344, 1'b1, 32'hBEEF3344, 32'h40, LAT + 2, LAT + 3, 1'b0});
    tbl.push_back('{2'b00, 32'h5E, 32'hCAFEF00D, 32'h0,      1'b1, 32'hCAFEF00D, 32'h5C, 1,       2,       1'b0});
`endif

    foreach (tbl[i]) begin
      idx = int'(tbl[i].ad[7:2]);
      preload(idx, tbl[i].init);
      run_store(tbl[i].sz, tbl[i].ad, tbl[i].rb, 1, wk, wc, dk, wa, wd, ms, ba, viol);
      check($sformatf("v%0d_wrcnt", i), 32'(wc), tbl[i].wr ? 32'd1 : 32'd0);
      if (tbl[i].wr) begin
        check($sformatf("v%0d_wr_k", i), 32'(wk), 32'(tbl[i].wk));
        check($sformatf("v%0d_addr", i), wa, tbl[i].maddr);
        check($sformatf("v%0d_data", i), wd, tbl[i].word);
        ref_mem[idx] = tbl[i].word;
      end
      check($sformatf("v%0d_done_k", i), 32'(dk), 32'(tbl[i].dk));
      check($sformatf("v%0d_mis", i), {31'b0, ms}, {31'b0, tbl[i].mis});
      check($sformatf("v%0d_busy_after", i), {31'b0, ba}, 32'h0);
      check($sformatf("v%0d_protocol", i), 32'(viol), 32'h0);
      check($sformatf("v%0d_mem", i), mem[idx], ref_mem[idx]);
    end

    // asynchronous reset while the sb write strobe is high
    preload(24, 32'h11223344);
    StoreSize = 2'b10; Address = 32'h61; RegB = 32'h000000EE; start = 1'b1;
    wk = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (MemWr) begin wk = k; break; end
    end
    check("rst_mid_wr_seen", 32'(wk), 32'(LAT + 2));
    #1 reset = 1'b0;
    #1;
    check("rst_mid_memwr", {31'b0, MemWr}, 32'h0);
    check("rst_mid_busy",  {31'b0, busy}, 32'h0);
    check("rst_mid_done",  {31'b0, done}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_mem", mem[24], ref_mem[24]);
    run_store(2'b00, 32'h64, 32'h0BADF00D, 1, wk, wc, dk, wa, wd, ms, ba, viol);
    check("post_rst_sw_data", wd, 32'h0BADF00D);
    check("post_rst_sw_addr", wa, 32'h64);
    check("post_rst_sw_k", 32'(wk), 32'd1);
    ref_mem[25] = 32'h0BADF00D;

    // start held through the whole sb, then re-issued right after done
    preload(26, 32'hA0B1C2D3);
    run_store(2'b10, 32'h69, 32'h00000077, LAT + 4, wk, wc, dk, wa, wd, ms, ba, viol);
    check("hold_wrcnt", 32'(wc), 32'd1);
    check("hold_data", wd, 32'hA0B177D3);
    check("hold_done_k", 32'(dk), 32'(LAT + 3));
    ref_mem[26] = 32'hA0B177D3;
    run_store(2'b01, 32'h6A, 32'h00004455, 1, wk, wc, dk, wa, wd, ms, ba, viol);
    check("b2b_wrcnt", 32'(wc), 32'd1);
    check("b2b_data", wd, 32'h4455_77D3);
    ref_mem[26] = 32'h445577D3;

    for (int n = 0; n < 40; n++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 32'($urandom_range(0, 255));
      rb = $urandom;
      idx = int'(ad / 4);
      flt = ref_fault(sz, ad);
      exp_w = ref_merge(sz, ad, rb, ref_mem[idx]);
      exp_dk = flt ? 1 : ((sz == 2'b01 || sz == 2'b10) ? LAT + 3 : 2);
      run_store(sz, ad, rb, 1, wk, wc, dk, wa, wd, ms, ba, viol);
      check($sformatf("r%0d_wrcnt", n), 32'(wc), flt ? 32'd0 : 32'd1);
      check($sformatf("r%0d_done_k", n), 32'(dk), 32'(exp_dk));
      check($sformatf("r%0d_mis", n), {31'b0, ms}, {31'b0, flt});
      check($sformatf("r%0d_protocol", n), 32'(viol), 32'h0);
      if (!flt) begin
        check($sformatf("r%0d_addr", n), wa, ad & 32'hFFFF_FFFC);
        check($sformatf("r%0d_data", n), wd, exp_w);
        ref_mem[idx] = exp_w;
      end
      check($sformatf("r%0d_mem", n), mem[idx], ref_mem[idx]);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
